tmem_ctrl: RTL and testbench
============================

# tmem_ctrl

Clocked digital front-end for the ring-based temporal memory cell. It converts a digital value into a write-enable pulse whose width is that many clock cycles. On a read it pulses read-enable and measures, in clock cycles, when the cell's asynchronous `out` rises. It is the writer and reader for the cell: it sits between a valid/ready command/response interface and the cell's `WE`/`RE`/`out` pins.

## Interface
Parameters:
- `WIDTH`, 8, value width in bits; the largest representable duration is 2**WIDTH-1 cycles
- `GAP_CYCLES`, 2, idle cycles forced after every `we`/`re` pulse before the next command is accepted

Ports:
- `clk`  in  1  single clock
- `rstb`  in  1  asynchronous, active-low reset
- `cmd_valid`  in  1  command offered
- `cmd_ready`  out  1  command accepted on `cmd_valid & cmd_ready` at a rising clock edge
- `cmd_write`  in  1  1 = write, 0 = read
- `cmd_data`  in  WIDTH  write duration in cycles; ignored for reads
- `we`  out  1  registered write-enable to the cell
- `re`  out  1  registered read-enable to the cell
- `mem_out`  in  1  asynchronous cell output
- `rsp_valid`  out  1  read result available; held until accepted
- `rsp_ready`  in  1  result consumed on `rsp_valid & rsp_ready`
- `rsp_data`  out  WIDTH  measured cycle index
- `rsp_timeout`  out  1  no edge was seen within range

## Operation
- States: IDLE, WRITE, READ, RESP, GAP.
- IDLE:
  - `cmd_ready`=1.
  - On accept with `cmd_write`=1 and `cmd_data`>0: load `cmd_data` into the down-counter and go to WRITE.
  - On accept with `cmd_write`=1 and `cmd_data`==0: go to GAP; no pulse is produced.
  - On accept with `cmd_write`=0: clear `cnt` and go to READ.
- WRITE:
  - `we`=1 for exactly `cmd_data` cycles, then GAP.
- READ:
  - `re`=1 from the first READ cycle, which is `cnt`=0.
  - `cnt` (WIDTH+2 bits) increments every cycle.
  - `mem_out` passes through a 2-flop synchronizer giving `s2`.
  - Detect condition: the first cycle with `cnt`>=2 and `s2`=1.
  - On detect: `rsp_data`=`cnt`-2, `rsp_timeout`=0, go to RESP.
  - `rsp_data` therefore equals the index of the READ cycle at whose closing edge `mem_out` was first sampled high.
  - Timeout: if `cnt` reaches 2**WIDTH+2 with no detect, set `rsp_data`=all ones, `rsp_timeout`=1, go to RESP.
- RESP:
  - `re`=0, `rsp_valid`=1.
  - On `rsp_ready`, go to GAP.
- GAP:
  - Count `GAP_CYCLES` cycles, then go to IDLE.
- Invariants:
  - `we` and `re` are never high in the same cycle.
  - Neither is high outside WRITE/READ.
  - `cmd_ready`=0 in every state except IDLE.
- Stale high: if `mem_out` is already high when READ starts, the result is `rsp_data`=0. No rising edge is required.
- `rsp_data`/`rsp_timeout` are stable while `rsp_valid`=1.

## Timing
- Reset (`rstb`=0, asynchronous):
  - state=IDLE.
  - `we`, `re`, `rsp_valid`, `rsp_timeout`, `cnt`, `rsp_data` and the synchronizer flops = 0.
  - `cmd_ready`=0 while `rstb`=0, and 1 from the first edge after release.
- Reset mid-WRITE/READ: `we`/`re` drop immediately, without waiting for `clk`. No response is issued.
- Write accepted at edge A:
  - `we`=1 in cycles A+1..A+N.
  - GAP occupies the next `GAP_CYCLES` cycles.
  - `cmd_ready`=1 again in cycle A+N+1+`GAP_CYCLES`.
- Write with N=0 accepted at edge A: `cmd_ready`=1 in cycle A+1+`GAP_CYCLES`.
- Read accepted at edge A:
  - `re`=1 from cycle A+1.
  - If `mem_out` is first sampled high at the end of READ cycle c, then `re` falls and `rsp_valid` rises at the edge ending READ cycle c+2.
- Response latency: `rsp_valid` may stay high indefinitely under backpressure. `re` stays low during RESP.

## Structure
- Shared package `tmem_pkg`:
  - state encoding
  - `TMEM_SYNC_STAGES`=2
  - default `GAP_CYCLES`
  - the `cnt` width rule WIDTH+2
- Sub-module `tmem_sync`: the 2-flop synchronizer with async active-low reset to 0. It is reused by other temporal-memory readers.
- The FSM, counters and response register stay in `tmem_ctrl`.

## Test plan
- Reset release with `cmd_valid`=0 → all outputs 0, then `cmd_ready`=1 one edge later. Assert `rstb` mid-READ → `re`=0 asynchronously and no `rsp_valid`.
- Write with `cmd_data`=5 → `we` high for exactly 5 cycles and `re` stays 0. `cmd_ready` returns 2 cycles after `we` falls. Repeat with `cmd_data`=0 → no `we` pulse.
- Read where the model raises `mem_out` 7 cycles after `re` rises (first sampled high at end of cycle 7) → `rsp_data`=7, `rsp_timeout`=0.
- Read with `mem_out` already high → `rsp_data`=0. Read with `mem_out` never rising (WIDTH=8) → `rsp_timeout`=1, `rsp_data`=255, and `re` drops after cycle 257.
- Hold `rsp_ready`=0 for 10 cycles → `rsp_valid` and `rsp_data` hold, `cmd_ready`=0 throughout, and the next command is accepted only after the handshake plus the GAP.
- Back-to-back write of 12 then read against the cell model → `rsp_data`=12±2. Check every cycle that `we` and `re` are never both 1.

Source files
------------

// File: rtl/tmem_pkg.sv
// Shared definitions for the temporal-memory front-ends: state encoding,
// synchronizer depth, default gap length and the cycle-counter width rule.
package tmem_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WRITE = 3'd1,
    ST_READ  = 3'd2,
    ST_RESP  = 3'd3,
    ST_GAP   = 3'd4
  } tmem_state_e;

  localparam int TMEM_SYNC_STAGES = 2;
  localparam int TMEM_GAP_CYCLES  = 2;

  // Two extra bits cover the synchronizer latency past the last valid index.
  function automatic int tmem_cnt_w(input int width);
    return width + 2;
  endfunction

endpackage

// File: rtl/tmem_sync.sv
// Multi-flop synchronizer for the cell's asynchronous output, reset to 0.
module tmem_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rstb,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff;

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) ff <= '0;
    else       ff <= {ff[STAGES-2:0], d};
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/tmem_ctrl.sv
// Temporal-memory writer/reader: turns a value into a WE pulse width and
// measures the delay from RE to the cell output rising.
module tmem_ctrl
  import tmem_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int GAP_CYCLES = TMEM_GAP_CYCLES   // must be >= 1
) (
  input  logic             clk,
  input  logic             rstb,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_write,
  input  logic [WIDTH-1:0] cmd_data,
  output logic             we,
  output logic             re,
  input  logic             mem_out,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_timeout
);

  localparam int CW = tmem_cnt_w(WIDTH);
  localparam logic [CW-1:0] ONE      = CW'(1);
  localparam logic [CW-1:0] TWO      = CW'(2);
  localparam logic [CW-1:0] GAP_LOAD = CW'(GAP_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'((1 << WIDTH) + 1);

  tmem_state_e    state, state_nxt;
  logic [CW-1:0]  cnt, cnt_nxt;
  logic           s2, detect, rsp_load, rsp_to_nxt;

  tmem_sync #(.STAGES(TMEM_SYNC_STAGES)) u_sync (
    .clk  (clk),
    .rstb (rstb),
    .d    (mem_out),
    .q    (s2)
  );

  // The first two READ cycles only see pre-read history through the synchronizer.
  assign detect = (cnt >= TWO) && s2;

  // cnt is shared: down-counter in WRITE and GAP, up-counter in READ.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    rsp_load   = 1'b0;
    rsp_to_nxt = 1'b0;
    case (state)
      ST_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          if (!cmd_write) begin
            state_nxt = ST_READ;
            cnt_nxt   = '0;
          end else if (cmd_data != '0) begin
            state_nxt = ST_WRITE;
            cnt_nxt   = CW'(cmd_data);
          end else begin
            state_nxt = ST_GAP;
            cnt_nxt   = GAP_LOAD;
          end
        end
      end
      ST_WRITE: begin
        if (cnt == ONE) begin
          state_nxt = ST_GAP;
          cnt_nxt   = GAP_LOAD;
        end else begin
          cnt_nxt = cnt - ONE;
        end
      end
      ST_READ: begin
        cnt_nxt = cnt + ONE;
        if (detect) begin
          state_nxt = ST_RESP;
          rsp_load  = 1'b1;
        end else if (cnt == CNT_LAST) begin
          state_nxt  = ST_RESP;
          rsp_load   = 1'b1;
          rsp_to_nxt = 1'b1;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_nxt = ST_GAP;
          cnt_nxt   = GAP_LOAD;
        end
      end
      ST_GAP: begin
        if (cnt <= ONE) state_nxt = ST_IDLE;
        else            cnt_nxt   = cnt - ONE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      we          <= 1'b0;
      re          <= 1'b0;
      cmd_ready   <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_data    <= '0;
      rsp_timeout <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      we        <= (state_nxt == ST_WRITE);
      re        <= (state_nxt == ST_READ);
      cmd_ready <= (state_nxt == ST_IDLE);
      rsp_valid <= (state_nxt == ST_RESP);
      if (rsp_load) begin
        rsp_data    <= rsp_to_nxt ? '1 : WIDTH'(cnt - TWO);
        rsp_timeout <= rsp_to_nxt;
      end
    end
  end

endmodule

// File: tb/tb_tmem_ctrl.sv
// Self-checking bench for tmem_ctrl: hand-written reset sequences, a table of
// directed commands and randomized commands scored against a behavioural model.
module tb_tmem_ctrl;

  localparam int WIDTH = 8;
  localparam int GAP   = 2;
  localparam int NEVER = 10000;

  logic             clk, rstb;
  logic             cmd_valid, cmd_ready, cmd_write;
  logic [WIDTH-1:0] cmd_data;
  logic             we, re, mem_out;
  logic             rsp_valid, rsp_ready, rsp_timeout;
  logic [WIDTH-1:0] rsp_data;

  int n_chk  = 0;
  int n_fail = 0;

  tmem_ctrl #(.WIDTH(WIDTH), .GAP_CYCLES(GAP)) dut (
    .clk         (clk),
    .rstb        (rstb),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_write   (cmd_write),
    .cmd_data    (cmd_data),
    .we          (we),
    .re          (re),
    .mem_out     (mem_out),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_data    (rsp_data),
    .rsp_timeout (rsp_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s/%s: got %0d, expected %0d", tag, name, act, exp);
    end
  endtask

  // we/re exclusive; nothing pulses or responds while ready for a command.
  always @(negedge clk) begin
    if (rstb) begin
      n_chk++;
      if ((we && re) || (cmd_ready && (we || re || rsp_valid))) begin
        n_fail++;
        $display("FAIL invariant: we=%0d re=%0d cmd_ready=%0d rsp_valid=%0d at %0t",
                 we, re, cmd_ready, rsp_valid, $time);
      end
    end
  end

  // delay: READ cycle index at whose closing edge mem_out is first high;
  // negative = already high before the read, huge = never.
  function automatic void model(input bit wr, input int data, input int delay,
                                output int len, output int dat, output bit to);
    int maxv;
    maxv = (1 << WIDTH) - 1;
    to   = 1'b0;
    dat  = 0;
    if (wr)              len = data;
    else if (delay < 0)  len = 3;
    else if (delay <= maxv) begin
      len = delay + 3;
      dat = delay;
    end else begin
      len = maxv + 3;
      dat = maxv;
      to  = 1'b1;
    end
  endfunction

  task automatic run_cmd(input string tag, input bit wr, input int data, input int delay,
                         input int hold, input int exp_len, input int exp_data, input bit exp_to,
                         output int meas_len, output int meas_data);
    int k, w, we_cnt, we_first, re_cnt, re_first, rv_cnt, rv_first, ready_k, d0, unstable;
    bit t0;
    we_cnt = 0; re_cnt = 0; rv_cnt = 0; unstable = 0;
    we_first = -1; re_first = -1; rv_first = -1; ready_k = -1; d0 = -1; t0 = 1'b0;
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_data  = WIDTH'(data);
    if (!wr && delay < 0) mem_out = 1'b1;
    w = 0;
    while (!cmd_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    chk(tag, "accept", int'(cmd_ready), 1);
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_data  = '0;
    k = 1;
    while (k < 1000) begin
      if (we) begin
        if (we_cnt == 0) we_first = k;
        we_cnt++;
      end
      if (re) begin
        if (re_cnt == 0) re_first = k;
        re_cnt++;
        if (!wr && (k - 1) == delay) mem_out = 1'b1;
      end
      if (cmd_ready) begin
        ready_k = k;
        break;
      end
      rsp_ready = 1'b0;
      if (rsp_valid) begin
        if (rv_cnt == 0) begin
          rv_first = k;
          d0 = int'(rsp_data);
          t0 = rsp_timeout;
        end else if (int'(rsp_data) != d0 || rsp_timeout != t0) begin
          unstable++;
        end
        rv_cnt++;
        if (rv_cnt > hold) rsp_ready = 1'b1;
      end
      @(negedge clk);
      k++;
    end
    rsp_ready = 1'b0;
    mem_out   = 1'b0;
    if (wr) begin
      chk(tag, "we_len", we_cnt, exp_len);
      if (exp_len > 0) chk(tag, "we_first", we_first, 1);
      chk(tag, "re_len", re_cnt, 0);
      chk(tag, "rsp_count", rv_cnt, 0);
      chk(tag, "ready_at", ready_k, exp_len + 1 + GAP);
      meas_len = we_cnt;
    end else begin
      chk(tag, "we_len", we_cnt, 0);
      chk(tag, "re_first", re_first, 1);
      chk(tag, "re_len", re_cnt, exp_len);
      chk(tag, "rsp_first", rv_first, exp_len + 1);
      chk(tag, "rsp_data", d0, exp_data);
      chk(tag, "rsp_timeout", int'(t0), int'(exp_to));
      chk(tag, "rsp_stable", unstable, 0);
      chk(tag, "ready_at", ready_k, exp_len + 1 + hold + 1 + GAP);
      meas_len = re_cnt;
    end
    meas_data = d0;
  endtask

  typedef struct {
    bit wr;
    int data;
    int delay;
    int hold;
    int exp_len;
    int exp_data;
    bit exp_to;
  } vec_t;

  initial begin
    vec_t vecs[11];
    int ml, md, wlen, elen, edat;
    bit eto;
    int rwr, rdata, rdel, rhold, r;

    vecs[0]  = '{1'b1,   5,     0,  0,   5,   0, 1'b0};
    vecs[1]  = '{1'b1,   0,     0,  0,   0,   0, 1'b0};
    vecs[2]  = '{1'b1,   1,     0,  0,   1,   0, 1'b0};
    vecs[3]  = '{1'b1, 255,     0,  0, 255,   0, 1'b0};
    vecs[4]  = '{1'b0,   0,     7,  0,  10,   7, 1'b0};
    vecs[5]  = '{1'b0,   0,    -1,  0,   3,   0, 1'b0};
    vecs[6]  = '{1'b0,   0,     0,  1,   3,   0, 1'b0};
    vecs[7]  = '{1'b0,   0, NEVER,  2, 258, 255, 1'b1};
    vecs[8]  = '{1'b0,   0,   255,  0, 258, 255, 1'b0};
    vecs[9]  = '{1'b0,   0,   256,  0, 258, 255, 1'b1};
    vecs[10] = '{1'b0,   0,     3, 10,   6,   3, 1'b0};

    rstb = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_data = '0;
    mem_out = 1'b0; rsp_ready = 1'b0;

    // Reset state, then cmd_ready one edge after release.
    #1;
    chk("reset", "we", int'(we), 0);
    chk("reset", "re", int'(re), 0);
    chk("reset", "cmd_ready", int'(cmd_ready), 0);
    chk("reset", "rsp_valid", int'(rsp_valid), 0);
    chk("reset", "rsp_data", int'(rsp_data), 0);
    chk("reset", "rsp_timeout", int'(rsp_timeout), 0);
    repeat (3) @(negedge clk);
    chk("reset", "cmd_ready_held", int'(cmd_ready), 0);
    rstb = 1'b1;
    #1;
    chk("release", "cmd_ready_pre_edge", int'(cmd_ready), 0);
    @(negedge clk);
    chk("release", "cmd_ready_post_edge", int'(cmd_ready), 1);

    foreach (vecs[i])
      run_cmd($sformatf("vec%0d", i), vecs[i].wr, vecs[i].data, vecs[i].delay, vecs[i].hold,
              vecs[i].exp_len, vecs[i].exp_data, vecs[i].exp_to, ml, md);

    // Back-to-back write 12 then read against a cell that replays the pulse width.
    run_cmd("b2b_wr", 1'b1, 12, 0, 0, 12, 0, 1'b0, wlen, md);
    model(1'b0, 0, wlen, elen, edat, eto);
    run_cmd("b2b_rd", 1'b0, 0, wlen, 0, elen, edat, eto, ml, md);
    n_chk++;
    if (md < 10 || md > 14) begin
      n_fail++;
      $display("FAIL b2b/readback: got %0d, expected 12+-2", md);
    end

    for (int i = 0; i < 30; i++) begin
      rwr   = int'($urandom_range(0, 1));
      rdata = int'($urandom_range(0, 20));
      r     = int'($urandom_range(0, 9));
      rdel  = (r == 0) ? -1 : (r == 1) ? 300 : int'($urandom_range(0, 40));
      rhold = int'($urandom_range(0, 4));
      model(rwr[0], rdata, rdel, elen, edat, eto);
      run_cmd($sformatf("rnd%0d", i), rwr[0], rdata, rdel, rhold, elen, edat, eto, ml, md);
    end

    // Reset mid-READ: re drops without a clock edge and no response follows.
    cmd_valid = 1'b1; cmd_write = 1'b0;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("midreset", "re_before", int'(re), 1);
    #2 rstb = 1'b0;
    #1;
    chk("midreset", "re_async", int'(re), 0);
    chk("midreset", "cmd_ready", int'(cmd_ready), 0);
    @(negedge clk);
    rstb = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("midreset", "no_rsp", int'(rsp_valid), 0);
    end
    chk("midreset", "ready_after", int'(cmd_ready), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, %0d failures so far", n_fail);
    $fatal(1, "watchdog");
  end

endmodule
